// File: rtl/fu_issue_scheduler.sv
// Issue sequencer for a 3-lane FU FIFO: picks free lanes in rotating priority, runs a
// per-FU IDLE/BUSY/DONE FSM with a latency down-counter, and holds results until CDB grant.
module fu_issue_scheduler #(
  parameter int LATENCY    = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          squash,
  input  logic [$clog2(FIFO_DEPTH):0]   fifo_avail,
  input  logic [2:0]                    cdb_gnt,
  output logic [2:0]                    rd_EN,
  output logic [2:0]                    cdb_req,
  output logic [2:0]                    fu_busy,
  output logic [1:0]                    issue_count
);

  localparam int CW = $clog2(LATENCY) + 1;
  localparam int AW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } fu_state_t;

  fu_state_t       r_state [3];
  logic [CW-1:0]   r_cnt   [3];
  logic [1:0]      r_rr_ptr;

  logic            w_flush;
  logic [2:0]      w_free;
  logic [2:0]      w_rd_en;
  logic [AW-1:0]   w_n;
  logic [1:0]      w_lane;
  logic [1:0]      w_last;
  logic [1:0]      w_rr_next;

  function automatic logic [1:0] rot_lane(input logic [1:0] ptr, input logic [1:0] k);
    logic [2:0] s;
    s = {1'b0, ptr} + {1'b0, k};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  assign w_flush = reset | squash;

  // A DONE FU whose result is being granted this cycle can accept a new op immediately.
  always_comb begin
    w_free = '0;
    for (int i = 0; i < 3; i++) begin
      w_free[i] = (r_state[i] == IDLE) || ((r_state[i] == DONE) && cdb_gnt[i]);
    end
  end

  always_comb begin
    w_rd_en = '0;
    w_n     = '0;
    w_lane  = '0;
    w_last  = r_rr_ptr;
    for (int k = 0; k < 3; k++) begin
      w_lane = rot_lane(r_rr_ptr, 2'(k));
      if (w_free[w_lane] && (w_n < fifo_avail)) begin
        w_rd_en[w_lane] = 1'b1;
        w_n             = w_n + AW'(1);
        w_last          = w_lane;
      end
    end
    if (w_flush) w_rd_en = '0;
  end

  assign w_rr_next = (w_n != '0) ? ((w_last == 2'd2) ? 2'd0 : w_last + 2'd1) : r_rr_ptr;

  assign rd_EN       = w_rd_en;
  assign issue_count = {1'b0, w_rd_en[0]} + {1'b0, w_rd_en[1]} + {1'b0, w_rd_en[2]};

  always_comb begin
    cdb_req = '0;
    fu_busy = '0;
    for (int i = 0; i < 3; i++) begin
      cdb_req[i] = !w_flush && (r_state[i] == DONE);
      fu_busy[i] = !w_flush && (r_state[i] != IDLE);
    end
  end

  always_ff @(posedge clock) begin
    if (w_flush) begin
      r_rr_ptr <= '0;
      for (int i = 0; i < 3; i++) begin
        r_state[i] <= IDLE;
        r_cnt[i]   <= '0;
      end
    end else begin
      r_rr_ptr <= w_rr_next;
      for (int i = 0; i < 3; i++) begin
        if (w_rd_en[i]) begin
          r_state[i] <= BUSY;
          r_cnt[i]   <= CW'(LATENCY - 1);
        end else begin
          case (r_state[i])
            BUSY: begin
              if (r_cnt[i] == '0) r_state[i] <= DONE;
              else                r_cnt[i]   <= r_cnt[i] - CW'(1);
            end
            DONE: begin
              if (cdb_gnt[i]) r_state[i] <= IDLE;
            end
            default: r_state[i] <= r_state[i];
          endcase
        end
      end
    end
  end

  // The FIFO cannot report more entries than it holds.
  assert property (@(posedge clock) disable iff (reset) fifo_avail <= AW'(FIFO_DEPTH));

endmodule

// File: tb/tb_fu_issue_scheduler.sv
// Bench for fu_issue_scheduler: directed scenario tasks with a completion scoreboard
// (expected CDB-request cycles queued at issue time, popped when cdb_req rises).
module tb_fu_issue_scheduler;
  localparam int LATENCY    = 4;
  localparam int FIFO_DEPTH = 8;

  logic       clock;
  logic       reset;
  logic       squash;
  logic [3:0] fifo_avail;
  logic [2:0] cdb_gnt;
  logic [2:0] rd_EN;
  logic [2:0] cdb_req;
  logic [2:0] fu_busy;
  logic [1:0] issue_count;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  typedef struct {int lane; int due;} exp_t;
  exp_t       exp_q[$];
  exp_t       e;
  logic [2:0] prev;
  logic [2:0] rising;

  fu_issue_scheduler #(.LATENCY(LATENCY), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clock(clock), .reset(reset), .squash(squash), .fifo_avail(fifo_avail),
    .cdb_gnt(cdb_gnt), .rd_EN(rd_EN), .cdb_req(cdb_req), .fu_busy(fu_busy),
    .issue_count(issue_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d passed of %0d", n_pass, n_checks);
    $fatal(1);
  end

  task automatic drive(input logic r, input logic s, input logic [3:0] a, input logic [2:0] g);
    @(negedge clock);
    reset = r; squash = s; fifo_avail = a; cdb_gnt = g;
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 1'b0, 4'd3, 3'b000);
      n_checks++;
      if ({rd_EN, cdb_req, fu_busy, issue_count} !== 11'b0)
        $display("FAIL reset_outputs: got rd_EN=%b cdb_req=%b fu_busy=%b issue_count=%0d, expected all 0",
                 rd_EN, cdb_req, fu_busy, issue_count);
      else n_pass++;
    end
    drive(1'b0, 1'b0, 4'd0, 3'b000);
    n_checks++;
    if ({rd_EN, cdb_req, fu_busy} !== 9'b0)
      $display("FAIL reset_release: got rd_EN=%b cdb_req=%b fu_busy=%b, expected 000 000 000", rd_EN, cdb_req, fu_busy);
    else n_pass++;
  endtask

  task automatic test_basic_issue();
    int t0;
    drive(1'b0, 1'b0, 4'd3, 3'b111);
    t0 = cyc;
    n_checks++;
    if (rd_EN !== 3'b111 || issue_count !== 2'd3)
      $display("FAIL basic_issue: got rd_EN=%b issue_count=%0d, expected 111 3", rd_EN, issue_count);
    else n_pass++;
    for (int i = 0; i < 3; i++) exp_q.push_back('{lane: i, due: t0 + LATENCY + 1});
    for (int k = 1; k <= LATENCY; k++) begin
      drive(1'b0, 1'b0, 4'd0, 3'b111);
      n_checks++;
      if (fu_busy !== 3'b111 || cdb_req !== 3'b000)
        $display("FAIL basic_busy t+%0d: got fu_busy=%b cdb_req=%b, expected 111 000", k, fu_busy, cdb_req);
      else n_pass++;
    end
    prev = 3'b000;
    for (int c = 0; c < 8 && exp_q.size() > 0; c++) begin
      drive(1'b0, 1'b0, 4'd0, 3'b111);
      rising = cdb_req & ~prev;
      prev = cdb_req;
      while (exp_q.size() > 0 && rising[exp_q[0].lane]) begin
        e = exp_q.pop_front();
        rising[e.lane] = 1'b0;
        n_checks++;
        if (cyc !== e.due) $display("FAIL basic_done lane %0d: got cycle %0d, expected %0d", e.lane, cyc, e.due);
        else n_pass++;
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      $display("FAIL basic_done_timeout: got %0d results outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end else n_pass++;
    drive(1'b0, 1'b0, 4'd0, 3'b000);
    n_checks++;
    if (fu_busy !== 3'b000) $display("FAIL basic_retire: got fu_busy=%b, expected 000", fu_busy);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_en;
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 4'd1, 3'b000);
      exp_en = 3'b001 << k;
      n_checks++;
      if (rd_EN !== exp_en || issue_count !== 2'd1)
        $display("FAIL rr_step%0d: got rd_EN=%b issue_count=%0d, expected %b 1", k, rd_EN, issue_count, exp_en);
      else n_pass++;
      exp_q.push_back('{lane: k, due: cyc + LATENCY + 1});
    end
    drive(1'b0, 1'b0, 4'd1, 3'b000);
    n_checks++;
    if (rd_EN !== 3'b000) $display("FAIL rr_all_busy: got rd_EN=%b, expected 000", rd_EN);
    else n_pass++;
    prev = cdb_req;
    for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
      drive(1'b0, 1'b0, 4'd0, 3'b000);
      rising = cdb_req & ~prev;
      prev = cdb_req;
      while (exp_q.size() > 0 && rising[exp_q[0].lane]) begin
        e = exp_q.pop_front();
        rising[e.lane] = 1'b0;
        n_checks++;
        if (cyc !== e.due) $display("FAIL rr_done lane %0d: got cycle %0d, expected %0d", e.lane, cyc, e.due);
        else n_pass++;
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      $display("FAIL rr_done_timeout: got %0d results outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end else n_pass++;
  endtask

  task automatic test_back_to_back();
    drive(1'b0, 1'b0, 4'd0, 3'b111);
    drive(1'b0, 1'b0, 4'd1, 3'b000);
    n_checks++;
    if (rd_EN !== 3'b001) $display("FAIL b2b_setup0: got rd_EN=%b, expected 001", rd_EN);
    else n_pass++;
    drive(1'b0, 1'b0, 4'd2, 3'b000);
    n_checks++;
    if (rd_EN !== 3'b110) $display("FAIL b2b_setup12: got rd_EN=%b, expected 110", rd_EN);
    else n_pass++;
    for (int k = 0; k < 3; k++) drive(1'b0, 1'b0, 4'd0, 3'b000);
    drive(1'b0, 1'b0, 4'd1, 3'b001);
    n_checks++;
    if (cdb_req !== 3'b001 || fu_busy !== 3'b111 || rd_EN !== 3'b001)
      $display("FAIL b2b_reuse: got cdb_req=%b fu_busy=%b rd_EN=%b, expected 001 111 001", cdb_req, fu_busy, rd_EN);
    else n_pass++;
    exp_q.push_back('{lane: 0, due: cyc + LATENCY + 1});
    drive(1'b0, 1'b0, 4'd0, 3'b000);
    n_checks++;
    if (cdb_req !== 3'b110 || fu_busy !== 3'b111)
      $display("FAIL b2b_next: got cdb_req=%b fu_busy=%b, expected 110 111", cdb_req, fu_busy);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    prev = cdb_req;
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 1'b0, 4'd3, 3'b000);
      n_checks++;
      if (cdb_req[2] !== 1'b1 || rd_EN !== 3'b000)
        $display("FAIL backpressure cycle %0d: got cdb_req=%b rd_EN=%b, expected cdb_req[2]=1 rd_EN=000", k, cdb_req, rd_EN);
      else n_pass++;
      rising = cdb_req & ~prev;
      prev = cdb_req;
      while (exp_q.size() > 0 && rising[exp_q[0].lane]) begin
        e = exp_q.pop_front();
        rising[e.lane] = 1'b0;
        n_checks++;
        if (cyc !== e.due) $display("FAIL reuse_done lane %0d: got cycle %0d, expected %0d", e.lane, cyc, e.due);
        else n_pass++;
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      $display("FAIL reuse_done_timeout: got %0d results outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end else n_pass++;
    drive(1'b0, 1'b0, 4'd0, 3'b100);
    drive(1'b0, 1'b0, 4'd0, 3'b000);
    n_checks++;
    if (cdb_req !== 3'b011) $display("FAIL backpressure_release: got cdb_req=%b, expected 011", cdb_req);
    else n_pass++;
  endtask

  task automatic test_squash();
    drive(1'b0, 1'b0, 4'd3, 3'b111);
    n_checks++;
    if (rd_EN !== 3'b111 || issue_count !== 2'd3)
      $display("FAIL squash_setup: got rd_EN=%b issue_count=%0d, expected 111 3", rd_EN, issue_count);
    else n_pass++;
    drive(1'b0, 1'b0, 4'd0, 3'b000);
    drive(1'b0, 1'b1, 4'd3, 3'b000);
    n_checks++;
    if ({rd_EN, issue_count, fu_busy, cdb_req} !== 11'b0)
      $display("FAIL squash_cycle: got rd_EN=%b issue_count=%0d fu_busy=%b cdb_req=%b, expected all 0",
               rd_EN, issue_count, fu_busy, cdb_req);
    else n_pass++;
    drive(1'b0, 1'b0, 4'd1, 3'b000);
    n_checks++;
    if (fu_busy !== 3'b000 || cdb_req !== 3'b000 || rd_EN !== 3'b001)
      $display("FAIL squash_after: got fu_busy=%b cdb_req=%b rd_EN=%b, expected 000 000 001", fu_busy, cdb_req, rd_EN);
    else n_pass++;
  endtask

  task automatic test_avail_limits();
    drive(1'b0, 1'b1, 4'd0, 3'b000);
    drive(1'b0, 1'b0, 4'd2, 3'b000);
    n_checks++;
    if (rd_EN !== 3'b011 || issue_count !== 2'd2)
      $display("FAIL avail2_from0: got rd_EN=%b issue_count=%0d, expected 011 2", rd_EN, issue_count);
    else n_pass++;
    for (int k = 0; k < LATENCY; k++) drive(1'b0, 1'b0, 4'd0, 3'b000);
    drive(1'b0, 1'b0, 4'd2, 3'b011);
    n_checks++;
    if (cdb_req !== 3'b011 || rd_EN !== 3'b101 || issue_count !== 2'd2)
      $display("FAIL avail2_from2: got cdb_req=%b rd_EN=%b issue_count=%0d, expected 011 101 2", cdb_req, rd_EN, issue_count);
    else n_pass++;
    drive(1'b0, 1'b0, 4'(FIFO_DEPTH), 3'b111);
    n_checks++;
    if (rd_EN !== 3'b010 || issue_count !== 2'd1)
      $display("FAIL avail_max_one_free: got rd_EN=%b issue_count=%0d, expected 010 1", rd_EN, issue_count);
    else n_pass++;
    drive(1'b1, 1'b0, 4'd3, 3'b111);
    n_checks++;
    if ({rd_EN, cdb_req, fu_busy} !== 9'b0)
      $display("FAIL reset_midop: got rd_EN=%b cdb_req=%b fu_busy=%b, expected 000 000 000", rd_EN, cdb_req, fu_busy);
    else n_pass++;
    drive(1'b0, 1'b0, 4'd0, 3'b000);
    n_checks++;
    if (rd_EN !== 3'b000 || fu_busy !== 3'b000)
      $display("FAIL avail0: got rd_EN=%b fu_busy=%b, expected 000 000", rd_EN, fu_busy);
    else n_pass++;
    drive(1'b0, 1'b0, 4'd1, 3'b000);
    n_checks++;
    if (rd_EN !== 3'b001) $display("FAIL avail0_ptr_hold: got rd_EN=%b, expected 001", rd_EN);
    else n_pass++;
  endtask

  initial begin
    reset = 1'b1; squash = 1'b0; fifo_avail = 4'd3; cdb_gnt = 3'b000;
    test_reset();
    test_basic_issue();
    test_round_robin();
    test_back_to_back();
    test_backpressure();
    test_squash();
    test_avail_limits();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
